// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite scheduler.
// Record field widths follow SPR_HWIDTH/SPR_VWIDTH; the scheduler's HWIDTH/VWIDTH must match them.
package sprite_pkg;

  localparam int SPR_HWIDTH = 10;
  localparam int SPR_VWIDTH = 10;
  localparam int SPR_HSIZE  = 64;
  localparam int SPR_VSIZE  = 64;

  typedef struct packed {
    logic                  en;
    logic [SPR_HWIDTH-1:0] hoff;
    logic [SPR_VWIDTH-1:0] voff;
  } sprite_rec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational box test for one sprite: does the pixel fall inside [off, off+SIZE)?
module sprite_hit_test #(
  parameter int HWIDTH = 10,
  parameter int VWIDTH = 10,
  parameter int HSIZE  = 64,
  parameter int VSIZE  = 64
) (
  input  logic              en,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  input  logic [HWIDTH-1:0] hoff,
  input  logic [VWIDTH-1:0] voff,
  output logic              hit
);

  localparam logic [HWIDTH:0] HLIM = (HWIDTH+1)'(HSIZE);
  localparam logic [VWIDTH:0] VLIM = (VWIDTH+1)'(VSIZE);

  // The subtraction wraps modulo 2^W, so a pixel left of or above the origin
  // becomes a large distance and misses.
  logic [HWIDTH-1:0] hdist;
  logic [VWIDTH-1:0] vdist;

  assign hdist = hdata - hoff;
  assign vdist = vdata - voff;
  assign hit   = en && ({1'b0, hdist} < HLIM) && ({1'b0, vdist} < VLIM);

endmodule

// File: rtl/sprite_scheduler.sv
// Picks the lowest-index sprite covering each pixel and commits game-written
// shadow positions to the active set once per frame, so sprites never tear.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int HWIDTH  = SPR_HWIDTH,
  parameter int VWIDTH  = SPR_VWIDTH,
  parameter int HSIZE   = SPR_HSIZE,
  parameter int VSIZE   = SPR_VSIZE,
  parameter int NSPRITE = 4,
  parameter int IDW     = $clog2(NSPRITE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [HWIDTH-1:0] hdata,
  input  logic [VWIDTH-1:0] vdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDW-1:0]    wr_id,
  input  logic              wr_en,
  input  logic [HWIDTH-1:0] wr_hoff,
  input  logic [VWIDTH-1:0] wr_voff,
  output logic [HWIDTH-1:0] hdata_q,
  output logic [VWIDTH-1:0] vdata_q,
  output logic [HWIDTH-1:0] hoffset,
  output logic [VWIDTH-1:0] voffset,
  output logic [IDW-1:0]    sel_id,
  output logic              sel_hit,
  output logic              overrun
);

  sprite_rec_t  shadow [NSPRITE];
  sprite_rec_t  active [NSPRITE];
  sched_state_t state;
  logic [IDW-1:0] idx;
  logic [NSPRITE-1:0] hit;
  logic wr_fire;

  assign wr_fire = wr_valid && wr_ready;

  // NOTE: the record arrays are reset because "all sprites disabled" is the
  // architectural reset state, not just a simulation convenience.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSPRITE; i++) shadow[i] <= '0;
    end else if (wr_fire) begin
      shadow[wr_id] <= '{en: wr_en, hoff: wr_hoff, voff: wr_voff};
    end
  end

  // Commit walks one sprite per cycle; wr_ready is registered so it drops on
  // the same edge that enters COMMIT and rises on the edge that leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      wr_ready <= 1'b1;
      overrun  <= 1'b0;
      for (int i = 0; i < NSPRITE; i++) active[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= COMMIT;
            idx      <= '0;
            wr_ready <= 1'b0;
          end
        end
        COMMIT: begin
          active[idx] <= shadow[idx];
          if (frame_start) overrun <= 1'b1;
          if (idx == IDW'(NSPRITE - 1)) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
          end else begin
            idx <= idx + IDW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NSPRITE; g++) begin : g_hit
    sprite_hit_test #(
      .HWIDTH (HWIDTH),
      .VWIDTH (VWIDTH),
      .HSIZE  (HSIZE),
      .VSIZE  (VSIZE)
    ) u_hit (
      .en    (active[g].en),
      .hdata (hdata),
      .vdata (vdata),
      .hoff  (active[g].hoff),
      .voff  (active[g].voff),
      .hit   (hit[g])
    );
  end

  logic              sel_hit_d;
  logic [IDW-1:0]    sel_id_d;
  logic [HWIDTH-1:0] hoffset_d;
  logic [VWIDTH-1:0] voffset_d;

  // NOTE: combinational logic uses blocking assignments with defaults first,
  // so every path assigns every output and no latch is inferred.
  always_comb begin
    sel_hit_d = 1'b0;
    sel_id_d  = '0;
    hoffset_d = '0;
    voffset_d = '0;
    // Scanning downward lets the lowest matching index overwrite the others.
    for (int i = NSPRITE - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit_d = 1'b1;
        sel_id_d  = IDW'(i);
        hoffset_d = active[i].hoff;
        voffset_d = active[i].voff;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_hit <= 1'b0;
      sel_id  <= '0;
      hoffset <= '0;
      voffset <= '0;
      hdata_q <= '0;
      vdata_q <= '0;
    end else begin
      sel_hit <= sel_hit_d;
      sel_id  <= sel_id_d;
      hoffset <= hoffset_d;
      voffset <= voffset_d;
      hdata_q <= hdata;
      vdata_q <= vdata;
    end
  end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Shares one coordinate transformer and sprite ROM among NSPRITE sprites: each pixel cycle it picks the lowest-index enabled sprite whose box covers the pixel and drives that sprite's offsets and id to the transformer. Game logic writes sprite positions at any time through a valid/ready port into shadow registers. A frame-boundary state machine commits the shadow registers to the active set, so sprites never tear mid-frame. The block sits between the game FSM and the transformer/ROM in the video pipeline.

## Interface
- HWIDTH, 10, horizontal coordinate width
- VWIDTH, 10, vertical coordinate width
- HSIZE, 64, sprite box width in screen pixels (same for all sprites)
- VSIZE, 64, sprite box height in screen pixels
- NSPRITE, 4, number of sprites; at least 2
- IDW, $clog2(NSPRITE), sprite id width

- clk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- hdata  in  HWIDTH  current pixel x
- vdata  in  VWIDTH  current pixel y
- wr_valid  in  1  position write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_id  in  IDW  target sprite
- wr_en  in  1  sprite enable to store
- wr_hoff  in  HWIDTH  sprite x origin
- wr_voff  in  VWIDTH  sprite y origin
- hdata_q  out  HWIDTH  hdata delayed 1 cycle, aligned with the selection outputs
- vdata_q  out  VWIDTH  vdata delayed 1 cycle
- hoffset  out  HWIDTH  selected sprite x origin, to the transformer
- voffset  out  VWIDTH  selected sprite y origin
- sel_id  out  IDW  selected sprite, indexes the ROM bank
- sel_hit  out  1  some sprite covers the pixel
- overrun  out  1  sticky: frame_start arrived during COMMIT

## Operation
- Per sprite: shadow and active records {en, hoff, voff}. Reset clears both to zero, so all sprites are disabled.
- Write: on handshake, shadow[wr_id] <= {wr_en, wr_hoff, wr_voff}. A later write to the same id before commit overwrites the earlier one.
- Hit test for sprite i: active.en & ((hdata - hoff) mod 2^HWIDTH < HSIZE) & ((vdata - voff) mod 2^VWIDTH < VSIZE). The unsigned wrap in the subtraction is intended: a pixel left of or above the origin misses.
- Selection is fixed priority, lowest index wins. With no hit: sel_hit=0, sel_id=0, hoffset=0, voffset=0.
- FSM states:
  - IDLE: wr_ready=1. frame_start moves to COMMIT with idx=0.
  - COMMIT: wr_ready=0. Each cycle copies active[idx] <= shadow[idx] and increments idx. After idx=NSPRITE-1 it returns to IDLE.
- frame_start in COMMIT is ignored and sets overrun.
- A write accepted in the same cycle as frame_start (FSM in IDLE) lands in shadow before the commit reads it, so it is included in that commit.
- Reset mid-COMMIT returns to IDLE and clears all records, even if the commit was partially applied.

## Timing
- Selection outputs are registered: 1-cycle latency from hdata/vdata to hoffset/voffset/sel_id/sel_hit, aligned with hdata_q/vdata_q.
- COMMIT lasts exactly NSPRITE cycles, and wr_ready is low for exactly those cycles. The integration requirement is that NSPRITE is less than the blanking length.
- Active records change only during COMMIT. Selection for a pixel presented in commit cycle k sees the sprites 0..k-1 that have already been updated.
- Reset values: wr_ready=1, all selection outputs 0, hdata_q/vdata_q 0, overrun 0.

## Structure
- sprite_pkg holds:
  - sprite_rec_t struct {en, hoff, voff}
  - sched_state_t enum {IDLE, COMMIT}
  - default HSIZE/VSIZE constants
- Sub-module sprite_hit_test: combinational hit test for one sprite, instantiated NSPRITE times.
- The top level holds the record arrays, the priority encoder, the output register and the FSM.

## Test plan
- Reset, then write id 1 {en=1, hoff=100, voff=50}, no frame_start; pixel (120,60) -> sel_hit=0. The write stays in shadow.
- Pulse frame_start, then wait 4 cycles; pixel (120,60) -> one cycle later sel_hit=1, sel_id=1, hoffset=100, voffset=50, hdata_q=120.
- Sprites 0 and 2 both enabled at (100,50), committed; pixel (110,55) -> sel_id=0. Pixel (99,55) -> sel_hit=0, checking the wrap miss at the left edge.
- Write held valid during COMMIT -> wr_ready=0 for 4 cycles, then accepted in the first IDLE cycle. A second frame_start at COMMIT cycle 2 -> overrun=1 and stays 1.
- Write to id 3 in the same cycle as frame_start -> sprite 3 active after the commit.
- Assert rst_n low at COMMIT cycle 2 -> wr_ready=1, sel_hit=0, and all sprites miss after reset release.
